// File: rtl/riu_pkg.sv
// Shared RIU pipeline types: itype/instr encodings, RV32 opcode and funct constants,
// and the decoded-instruction bundle passed from the decoder into the F/EX register.
package riu_pkg;

    typedef enum logic [2:0] {
        IT_R       = 3'b000,
        IT_I       = 3'b001,
        IT_U       = 3'b010,
        IT_ILLEGAL = 3'b111
    } itype_t;

    typedef enum logic [3:0] {
        INSTR_AND   = 4'b0000,
        INSTR_OR    = 4'b0001,
        INSTR_XOR   = 4'b0010,
        INSTR_ADD   = 4'b0011,
        INSTR_SUB   = 4'b0100,
        INSTR_MUL   = 4'b0101,
        INSTR_MULH  = 4'b0110,
        INSTR_MULHU = 4'b0111,
        INSTR_SLL   = 4'b1000,
        INSTR_SRL   = 4'b1001,
        INSTR_SRA   = 4'b1010,
        INSTR_SLT   = 4'b1011,
        INSTR_SLTU  = 4'b1100,
        INSTR_CSRRW = 4'b1101,
        INSTR_LUI   = 4'b1110,
        INSTR_ILL   = 4'b1111
    } instr_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_SLTU  = 3'b011;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_SRL   = 3'b101;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    typedef struct packed {
        itype_t      itype;
        instr_t      instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [11:0] csr;
    } dec_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic logic [31:0] zext_shamt(input logic [4:0] v);
        return {27'b0, v};
    endfunction

endpackage

// File: rtl/rv_decoder.sv
// Purely combinational RV32 subset decoder: one instruction word in, decoded
// fields plus a legal flag out. Illegal words decode to itype 111 / instr 1111.
module rv_decoder
    import riu_pkg::*;
(
    input  logic [31:0] word,
    output dec_t        dec,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = word[6:0];
    assign f3     = word[14:12];
    assign f7     = word[31:25];

    always_comb begin
        dec.itype = IT_ILLEGAL;
        dec.instr = INSTR_ILL;
        dec.rd    = word[11:7];
        dec.rs1   = word[19:15];
        dec.rs2   = word[24:20];
        dec.imm   = '0;
        dec.csr   = word[31:20];
        legal     = 1'b0;

        case (opcode)
            OP_R: begin
                dec.itype = IT_R;
                legal     = 1'b1;
                case ({f7, f3})
                    {F7_BASE, F3_ADD}:  dec.instr = INSTR_ADD;
                    {F7_ALT,  F3_ADD}:  dec.instr = INSTR_SUB;
                    {F7_BASE, F3_AND}:  dec.instr = INSTR_AND;
                    {F7_BASE, F3_OR}:   dec.instr = INSTR_OR;
                    {F7_BASE, F3_XOR}:  dec.instr = INSTR_XOR;
                    {F7_BASE, F3_SLL}:  dec.instr = INSTR_SLL;
                    {F7_BASE, F3_SRL}:  dec.instr = INSTR_SRL;
                    {F7_ALT,  F3_SRL}:  dec.instr = INSTR_SRA;
                    {F7_BASE, F3_SLT}:  dec.instr = INSTR_SLT;
                    {F7_BASE, F3_SLTU}: dec.instr = INSTR_SLTU;
                    {F7_MUL,  F3_ADD}:  dec.instr = INSTR_MUL;
                    {F7_MUL,  F3_SLL}:  dec.instr = INSTR_MULH;
                    {F7_MUL,  F3_SLTU}: dec.instr = INSTR_MULHU;
                    default:            legal     = 1'b0;
                endcase
            end

            OP_I: begin
                dec.itype = IT_I;
                dec.imm   = sext12(word[31:20]);
                legal     = 1'b1;
                case (f3)
                    F3_ADD: dec.instr = INSTR_ADD;
                    F3_AND: dec.instr = INSTR_AND;
                    F3_OR:  dec.instr = INSTR_OR;
                    F3_XOR: dec.instr = INSTR_XOR;
                    F3_SLL: begin
                        dec.instr = INSTR_SLL;
                        dec.imm   = zext_shamt(word[24:20]);
                        legal     = (f7 == F7_BASE);
                    end
                    F3_SRL: begin
                        // funct7 picks logical vs arithmetic; the shamt never carries a sign
                        dec.imm = zext_shamt(word[24:20]);
                        if (f7 == F7_BASE) begin
                            dec.instr = INSTR_SRL;
                        end else if (f7 == F7_ALT) begin
                            dec.instr = INSTR_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end

            OP_LUI: begin
                dec.itype = IT_U;
                dec.instr = INSTR_LUI;
                dec.imm   = {word[31:12], 12'b0};
                dec.rs1   = '0;
                dec.rs2   = '0;
                legal     = 1'b1;
            end

            OP_SYS: begin
                if (f3 == F3_CSRRW) begin
                    dec.itype = IT_R;
                    dec.instr = INSTR_CSRRW;
                    legal     = 1'b1;
                end
            end

            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec.itype = IT_ILLEGAL;
            dec.instr = INSTR_ILL;
            dec.imm   = '0;
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// RIU front stage: PC, synchronous ROM address, decode and the F/EX register.
// Optional FD_ILLEGAL_HALT_EN: latching an illegal word halts fetch until reset.
module fetch_decode
    import riu_pkg::*;
#(
    parameter int          IMEM_AW  = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [2:0]         itype,
    output logic [3:0]         instr,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [31:0]        imm,
    output logic [11:0]        csr,
    output logic               valid,
    output logic               illegal
`ifdef FD_ILLEGAL_HALT_EN
    ,
    output logic               halted
`endif
);

    localparam logic [IMEM_AW-1:0] PC_INIT = IMEM_AW'(RESET_PC);

    logic [IMEM_AW-1:0] pc;
    logic               fetch_v;
    dec_t               dec;
    logic               legal;
    dec_t               fex;
    logic               valid_q;
    logic               illegal_q;
    logic               advance;

    rv_decoder u_dec (
        .word  (imem_rdata),
        .dec   (dec),
        .legal (legal)
    );

    // stall=1 freezes pc, fetch_v and F/EX for that edge; the ROM sees the same
    // address, so the word presented on imem_rdata is the one captured at resume.
`ifdef FD_ILLEGAL_HALT_EN
    assign advance = ~stall & ~illegal_q;
    assign halted  = illegal_q;
`else
    assign advance = ~stall;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= PC_INIT;
            fetch_v   <= 1'b0;
            fex       <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (advance) begin
            pc        <= pc + IMEM_AW'(1);
            fetch_v   <= 1'b1;
            fex       <= dec;
            valid_q   <= fetch_v & legal;
            illegal_q <= fetch_v & ~legal;
        end
    end

    assign imem_addr = pc;
    assign itype     = fex.itype;
    assign instr     = fex.instr;
    assign rd        = fex.rd;
    assign rs1       = fex.rs1;
    assign rs2       = fex.rs2;
    assign imm       = fex.imm;
    assign csr       = fex.csr;
    assign valid     = valid_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: random ROM program, random stalls, program-order reference
// built from a mask/match opcode table. Covers both builds of FD_ILLEGAL_HALT_EN.
module tb_fetch_decode;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;
    localparam int W     = 68;
    localparam int NENT  = 22;
    localparam logic [W-1:0] FULL  = {W{1'b1}};
    localparam logic [W-1:0] VMASK = {2'b11, {(W-2){1'b0}}};

    // clock / reset / DUT
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [2:0]    itype;
    logic [3:0]    instr;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic [11:0]   csr;
    logic          valid, illegal;
`ifdef FD_ILLEGAL_HALT_EN
    logic          halted;
`endif

    always #5 clk = ~clk;

    fetch_decode #(.IMEM_AW(AW), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .itype      (itype),
        .instr      (instr),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .csr        (csr),
        .valid      (valid),
        .illegal    (illegal)
`ifdef FD_ILLEGAL_HALT_EN
        ,
        .halted     (halted)
`endif
    );

    // synchronous ROM, read enable tied to ~stall
    logic [31:0] rom [DEPTH];
    always @(posedge clk) begin
        if (!stall) imem_rdata <= rom[imem_addr];
    end

    // reference decode table: an entry matches when (word & mask) == match
    logic [31:0] t_mask  [NENT];
    logic [31:0] t_match [NENT];
    logic [2:0]  t_itype [NENT];
    logic [3:0]  t_instr [NENT];
    int          t_immk  [NENT];   // 0 none, 1 sext12, 2 shamt, 3 upper20

    task automatic add_ent(input int i, input logic [31:0] m, input logic [31:0] mt,
                           input logic [2:0] it, input logic [3:0] ins, input int ik);
        t_mask[i] = m; t_match[i] = mt; t_itype[i] = it; t_instr[i] = ins; t_immk[i] = ik;
    endtask

    task automatic init_table();
        add_ent(0,  32'hFE00707F, 32'h00000033, 3'b000, 4'b0011, 0);  // add
        add_ent(1,  32'hFE00707F, 32'h40000033, 3'b000, 4'b0100, 0);  // sub
        add_ent(2,  32'hFE00707F, 32'h00001033, 3'b000, 4'b1000, 0);  // sll
        add_ent(3,  32'hFE00707F, 32'h00002033, 3'b000, 4'b1011, 0);  // slt
        add_ent(4,  32'hFE00707F, 32'h00003033, 3'b000, 4'b1100, 0);  // sltu
        add_ent(5,  32'hFE00707F, 32'h00004033, 3'b000, 4'b0010, 0);  // xor
        add_ent(6,  32'hFE00707F, 32'h00005033, 3'b000, 4'b1001, 0);  // srl
        add_ent(7,  32'hFE00707F, 32'h40005033, 3'b000, 4'b1010, 0);  // sra
        add_ent(8,  32'hFE00707F, 32'h00006033, 3'b000, 4'b0001, 0);  // or
        add_ent(9,  32'hFE00707F, 32'h00007033, 3'b000, 4'b0000, 0);  // and
        add_ent(10, 32'hFE00707F, 32'h02000033, 3'b000, 4'b0101, 0);  // mul
        add_ent(11, 32'hFE00707F, 32'h02001033, 3'b000, 4'b0110, 0);  // mulh
        add_ent(12, 32'hFE00707F, 32'h02003033, 3'b000, 4'b0111, 0);  // mulhu
        add_ent(13, 32'h0000707F, 32'h00000013, 3'b001, 4'b0011, 1);  // addi
        add_ent(14, 32'h0000707F, 32'h00004013, 3'b001, 4'b0010, 1);  // xori
        add_ent(15, 32'h0000707F, 32'h00006013, 3'b001, 4'b0001, 1);  // ori
        add_ent(16, 32'h0000707F, 32'h00007013, 3'b001, 4'b0000, 1);  // andi
        add_ent(17, 32'hFE00707F, 32'h00001013, 3'b001, 4'b1000, 2);  // slli
        add_ent(18, 32'hFE00707F, 32'h00005013, 3'b001, 4'b1001, 2);  // srli
        add_ent(19, 32'hFE00707F, 32'h40005013, 3'b001, 4'b1010, 2);  // srai
        add_ent(20, 32'h0000007F, 32'h00000037, 3'b010, 4'b1110, 3);  // lui
        add_ent(21, 32'h0000707F, 32'h00001073, 3'b000, 4'b1101, 0);  // csrrw
    endtask

    // {valid, illegal, itype, instr, rd, rs1, rs2, imm, csr} for a fetched word
    function automatic logic [W-1:0] ref_decode(input logic [31:0] w);
        logic [2:0]  it = 3'b111;
        logic [3:0]  ins = 4'b1111;
        logic [31:0] im = 32'd0;
        logic        ok = 1'b0;
        logic [4:0]  r1 = w[19:15];
        logic [4:0]  r2 = w[24:20];
        for (int i = 0; i < NENT; i++) begin
            if ((w & t_mask[i]) == t_match[i]) begin
                ok  = 1'b1;
                it  = t_itype[i];
                ins = t_instr[i];
                case (t_immk[i])
                    1:       im = 32'($signed(w[31:20]));
                    2:       im = 32'(w[24:20]);
                    3:       im = w & 32'hFFFFF000;
                    default: im = 32'd0;
                endcase
                if (t_immk[i] == 3) begin
                    r1 = 5'd0;
                    r2 = 5'd0;
                end
            end
        end
        return {ok, ~ok, it, ins, w[11:7], r1, r2, im, w[31:20]};
    endfunction

    function automatic logic [31:0] rand_legal();
        int i = $urandom_range(0, NENT - 1);
        return t_match[i] | ($urandom() & ~t_mask[i]);
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom();
        case ($urandom_range(0, 7))
            0:       return w;
            1:       return {w[31:7], 7'b0110011};
            2:       return {w[31:7], 7'b0010011};
            3:       return {w[31:7], 7'b1110011};
            default: return rand_legal();
        endcase
    endfunction

    function automatic logic [W-1:0] obs();
        return {valid, illegal, itype, instr, rd, rs1, rs2, imm, csr};
    endfunction

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;
    logic [W-1:0] last_mask;
    int           adv;
    logic         m_halted;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fex", 96'(obs()), 96'(0));
        check("rst_addr", 96'(imem_addr), 96'(0));
`ifdef FD_ILLEGAL_HALT_EN
        check("rst_halted", 96'(halted), 96'(0));
`endif
        rst_n     = 1'b1;
        adv       = 0;
        m_halted  = 1'b0;
        exp_q.delete();
        last_exp  = '0;
        last_mask = FULL;
    endtask

    task automatic step(input logic st);
        stall = st;
        if (!st && !m_halted) begin
            adv++;
            if (adv == 1) begin
                // first slot after reset is a bubble; only valid/illegal are defined
                last_exp  = '0;
                last_mask = VMASK;
            end else begin
                exp_q.push_back(ref_decode(rom[(adv - 2) % DEPTH]));
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            last_exp  = exp_q.pop_front();
            last_mask = FULL;
        end
        check("fex", 96'(obs() & last_mask), 96'(last_exp & last_mask));
        check("imem_addr", 96'(imem_addr), 96'(adv % DEPTH));
`ifdef FD_ILLEGAL_HALT_EN
        m_halted = m_halted | last_exp[W-2];
        check("halted", 96'(halted), 96'(m_halted));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init_table();
        for (int a = 0; a < DEPTH; a++) begin
`ifdef FD_ILLEGAL_HALT_EN
            rom[a] = rand_legal();
`else
            rom[a] = rand_word();
`endif
        end
        rom[0] = 32'h002081B3;
        rom[1] = 32'hFFF00293;
        rom[2] = 32'h40325213;
        rom[3] = 32'h123453B7;
        rom[4] = 32'hF0231073;
        rom[5] = 32'h02208433;
        rom[DEPTH-1] = rand_legal();

        // directed program start
        do_reset();
        step(1'b0);
        check("e1_valid", 96'(valid), 96'(0));
        check("e1_addr", 96'(imem_addr), 96'(1));
        step(1'b0);
        check("add_valid", 96'(valid), 96'(1));
        check("add_itype", 96'(itype), 96'(3'b000));
        check("add_instr", 96'(instr), 96'(4'b0011));
        check("add_regs", 96'({rd, rs1, rs2}), 96'({5'd3, 5'd1, 5'd2}));
        check("e2_addr", 96'(imem_addr), 96'(2));
        step(1'b0);
        check("addi_imm", 96'(imm), 96'(32'hFFFFFFFF));
        check("addi_instr", 96'(instr), 96'(4'b0011));
        step(1'b0);
        check("srai_imm", 96'(imm), 96'(3));
        check("srai_instr", 96'(instr), 96'(4'b1010));
        check("srai_itype", 96'(itype), 96'(3'b001));
        step(1'b0);
        check("lui_imm", 96'(imm), 96'(32'h12345000));
        check("lui_itype", 96'(itype), 96'(3'b010));
        step(1'b0);
        check("csr_itype", 96'(itype), 96'(3'b000));
        check("csr_instr", 96'(instr), 96'(4'b1101));
        check("csr_num", 96'(csr), 96'(12'hF02));
        check("csr_rs1", 96'(rs1), 96'(6));
        step(1'b0);
        check("mul_instr", 96'(instr), 96'(4'b0101));
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            check("stall_instr", 96'(instr), 96'(4'b0101));
            check("stall_addr", 96'(imem_addr), 96'(7));
        end
        step(1'b0);
        check("resume_addr", 96'(imem_addr), 96'(8));

        // random stalls through the PC wrap
        for (int n = 0; n < 9000 && adv < DEPTH + 24; n++) begin
            logic st;
            st = ($urandom_range(0, 3) == 0);
            step(st);
            if (!st && (adv == DEPTH + 1 || adv == DEPTH + 2))
                check("wrap_valid", 96'(valid), 96'(1));
            if (!st && adv == DEPTH)
                check("wrap_addr", 96'(imem_addr), 96'(0));
        end
        check("wrap_reached", 96'(adv >= DEPTH + 24), 96'(1));

        // asynchronous reset in the middle of a stall
        step(1'b1);
        step(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_fex", 96'(obs()), 96'(0));
        check("async_rst_addr", 96'(imem_addr), 96'(0));
        do_reset();
        for (int k = 0; k < 40; k++) step($urandom_range(0, 2) == 0);

        // illegal word handling
        rom[2] = 32'hFFFFFFFF;
        rom[3] = 32'h002081B3;
        do_reset();
        repeat (4) step(1'b0);
        check("ill_flag", 96'(illegal), 96'(1));
        check("ill_valid", 96'(valid), 96'(0));
        check("ill_itype", 96'(itype), 96'(3'b111));
        check("ill_instr", 96'(instr), 96'(4'b1111));
        step(1'b1);
        step(1'b1);
        check("ill_stall_hold", 96'(illegal), 96'(1));
`ifdef FD_ILLEGAL_HALT_EN
        for (int k = 0; k < 6; k++) begin
            step($urandom_range(0, 1) == 1);
            check("halt_addr", 96'(imem_addr), 96'(4));
            check("halt_flag", 96'(halted), 96'(1));
        end
        do_reset();
        repeat (3) step(1'b0);
        check("post_halt_valid", 96'(valid), 96'(1));
`else
        step(1'b0);
        check("after_ill_valid", 96'(valid), 96'(1));
        check("after_ill_instr", 96'(instr), 96'(4'b0011));
        check("after_ill_clear", 96'(illegal), 96'(0));
        for (int k = 0; k < 20; k++) step($urandom_range(0, 2) == 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
